// File: rtl/mac_streamer_nch.sv
// mac_streamer_nch: multi-channel TCDM streamer for the HWPE MAC engine.
// NB_SRC read channels and NB_SNK write channels, each with a linear
// address generator and a credit-controlled FIFO. One start pulse runs
// every channel to completion.
// Optional build macro: MAC_STREAMER_STALL_CNT_EN enables the TCDM stall
// counter on stall_cnt_o; without it stall_cnt_o is tied to zero.
module mac_streamer_nch #(
   parameter int unsigned DW         = 32,
   parameter int unsigned AW         = 32,
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned NB_SRC     = 3,
   parameter int unsigned NB_SNK     = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                enable_i,
   input  logic                                clear_i,
   input  logic                                start_i,
   input  logic [NB_SRC*AW-1:0]                src_base_i,
   input  logic [NB_SRC*AW-1:0]                src_stride_i,
   input  logic [NB_SRC*LEN_W-1:0]             src_len_i,
   input  logic [NB_SNK*AW-1:0]                snk_base_i,
   input  logic [NB_SNK*AW-1:0]                snk_stride_i,
   input  logic [NB_SNK*LEN_W-1:0]             snk_len_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic [NB_SRC-1:0]                   src_done_o,
   output logic [NB_SNK-1:0]                   snk_done_o,
   output logic [NB_SRC+NB_SNK-1:0]            tcdm_req_o,
   input  logic [NB_SRC+NB_SNK-1:0]            tcdm_gnt_i,
   output logic [(NB_SRC+NB_SNK)*AW-1:0]       tcdm_add_o,
   output logic [NB_SRC+NB_SNK-1:0]            tcdm_wen_o,
   output logic [(NB_SRC+NB_SNK)*DW/8-1:0]     tcdm_be_o,
   output logic [(NB_SRC+NB_SNK)*DW-1:0]       tcdm_data_o,
   input  logic [(NB_SRC+NB_SNK)*DW-1:0]       tcdm_r_data_i,
   input  logic [NB_SRC+NB_SNK-1:0]            tcdm_r_valid_i,
   output logic [NB_SRC-1:0]                   src_valid_o,
   input  logic [NB_SRC-1:0]                   src_ready_i,
   output logic [NB_SRC*DW-1:0]                src_data_o,
   input  logic [NB_SNK-1:0]                   snk_valid_i,
   output logic [NB_SNK-1:0]                   snk_ready_o,
   input  logic [NB_SNK*DW-1:0]                snk_data_i,
   output logic [31:0]                         stall_cnt_o
);

   localparam int unsigned NCH = NB_SRC + NB_SNK;
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state;
   logic              soft_rst;
   logic              start_go;
   logic              run;
   logic              all_done_nx;
   logic [NB_SRC-1:0] src_done_nx;
   logic [NB_SNK-1:0] snk_done_nx;
   logic [NCH-1:0]    req;
   logic [NCH-1:0]    gnt_fire;

   assign soft_rst    = rst_i | clear_i;
   assign start_go    = (state == ST_IDLE) & start_i;
   assign run         = (state == ST_RUN);
   assign all_done_nx = &{src_done_nx, snk_done_nx};
   assign gnt_fire    = req & tcdm_gnt_i;

   assign busy_o     = run;
   assign done_o     = (state == ST_DONE);
   assign tcdm_req_o = req;
   assign tcdm_be_o  = '1;

   // Top FSM; leaves RUN on the same edge the last channel completes
   always_ff @(posedge clk_i) begin
      if (soft_rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start_i) state <= ST_RUN;
            ST_RUN:  if (all_done_nx) state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NB_SRC; i++) begin : g_src
      logic [AW-1:0]    addr;
      logic [AW-1:0]    stride;
      logic [LEN_W-1:0] len;
      logic [LEN_W-1:0] issued;
      logic [LEN_W-1:0] accepted;
      logic [CW-1:0]    occ;
      logic [CW-1:0]    outst;
      logic [PW-1:0]    wptr;
      logic [PW-1:0]    rptr;
      logic [DW-1:0]    mem [FIFO_DEPTH];
      logic             done_q;
      logic             hold;
      logic             can_issue;
      logic             push;
      logic             pop;
      logic             valid;

      // Credit rule: FIFO space is reserved for every read in flight
      assign can_issue = run && (issued < len) && ((occ + outst) < DEPTH_C);
      assign req[i]    = can_issue & (enable_i | hold);
      assign push      = tcdm_r_valid_i[i] & (outst != '0);
      assign valid     = run & enable_i & (occ != '0);
      assign pop       = valid & src_ready_i[i];
      assign src_done_nx[i] = done_q | (pop && (accepted == len - LEN_W'(1)));

      assign src_valid_o[i]            = valid;
      assign src_data_o[i*DW +: DW]    = valid ? mem[rptr] : '0;
      assign src_done_o[i]             = done_q;
      assign tcdm_add_o[i*AW +: AW]    = addr;
      assign tcdm_wen_o[i]             = 1'b1;
      assign tcdm_data_o[i*DW +: DW]   = '0;

      // Source channel counters, address generator and FIFO pointers
      always_ff @(posedge clk_i) begin
         if (soft_rst) begin
            addr     <= '0;
            stride   <= '0;
            len      <= '0;
            issued   <= '0;
            accepted <= '0;
            occ      <= '0;
            outst    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            done_q   <= 1'b0;
            hold     <= 1'b0;
         end else if (start_go) begin
            addr     <= src_base_i[i*AW +: AW];
            stride   <= src_stride_i[i*AW +: AW];
            len      <= src_len_i[i*LEN_W +: LEN_W];
            issued   <= '0;
            accepted <= '0;
            occ      <= '0;
            outst    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            done_q   <= (src_len_i[i*LEN_W +: LEN_W] == '0);
            hold     <= 1'b0;
         end else begin
            hold <= req[i] & ~tcdm_gnt_i[i];
            if (gnt_fire[i]) begin
               addr   <= addr + stride;
               issued <= issued + LEN_W'(1);
            end
            outst <= outst + CW'(gnt_fire[i]) - CW'(push);
            occ   <= occ + CW'(push) - CW'(pop);
            if (push) wptr <= wptr + PW'(1);
            if (pop) begin
               rptr     <= rptr + PW'(1);
               accepted <= accepted + LEN_W'(1);
            end
            done_q <= src_done_nx[i];
         end
      end

      // FIFO storage; contents are never observed unless occupancy covers them
      always_ff @(posedge clk_i) begin
         if (push) mem[wptr] <= tcdm_r_data_i[i*DW +: DW];
      end
   end

   for (genvar j = 0; j < NB_SNK; j++) begin : g_snk
      localparam int unsigned P = NB_SRC + j;
      logic [AW-1:0]    addr;
      logic [AW-1:0]    stride;
      logic [LEN_W-1:0] len;
      logic [LEN_W-1:0] issued;
      logic [LEN_W-1:0] accepted;
      logic [CW-1:0]    occ;
      logic [PW-1:0]    wptr;
      logic [PW-1:0]    rptr;
      logic [DW-1:0]    mem [FIFO_DEPTH];
      logic             done_q;
      logic             hold;
      logic             can_issue;
      logic             ready;
      logic             push;
      logic             pop;

      assign can_issue = run && (issued < len) && (occ != '0);
      assign req[P]    = can_issue & (enable_i | hold);
      assign ready     = run & enable_i & (occ != DEPTH_C) & (accepted < len);
      assign push      = ready & snk_valid_i[j];
      assign pop       = gnt_fire[P];
      assign snk_done_nx[j] = done_q | (pop && (issued == len - LEN_W'(1)));

      assign snk_ready_o[j]          = ready;
      assign snk_done_o[j]           = done_q;
      assign tcdm_add_o[P*AW +: AW]  = addr;
      assign tcdm_wen_o[P]           = ~req[P];
      assign tcdm_data_o[P*DW +: DW] = req[P] ? mem[rptr] : '0;

      // Sink channel counters, address generator and FIFO pointers
      always_ff @(posedge clk_i) begin
         if (soft_rst) begin
            addr     <= '0;
            stride   <= '0;
            len      <= '0;
            issued   <= '0;
            accepted <= '0;
            occ      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            done_q   <= 1'b0;
            hold     <= 1'b0;
         end else if (start_go) begin
            addr     <= snk_base_i[j*AW +: AW];
            stride   <= snk_stride_i[j*AW +: AW];
            len      <= snk_len_i[j*LEN_W +: LEN_W];
            issued   <= '0;
            accepted <= '0;
            occ      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            done_q   <= (snk_len_i[j*LEN_W +: LEN_W] == '0);
            hold     <= 1'b0;
         end else begin
            hold <= req[P] & ~tcdm_gnt_i[P];
            if (pop) begin
               addr   <= addr + stride;
               issued <= issued + LEN_W'(1);
               rptr   <= rptr + PW'(1);
            end
            if (push) begin
               wptr     <= wptr + PW'(1);
               accepted <= accepted + LEN_W'(1);
            end
            occ    <= occ + CW'(push) - CW'(pop);
            done_q <= snk_done_nx[j];
         end
      end

      // Sink FIFO storage
      always_ff @(posedge clk_i) begin
         if (push) mem[wptr] <= snk_data_i[j*DW +: DW];
      end
   end

   // Read responses on sink ports carry nothing of interest
   logic unused_snk_rsp;
   assign unused_snk_rsp = ^{tcdm_r_valid_i[NCH-1:NB_SRC], tcdm_r_data_i[NCH*DW-1:NB_SRC*DW]};

`ifdef MAC_STREAMER_STALL_CNT_EN
   logic [31:0] stall_cnt;

   // Saturating count of RUN cycles with any request left ungranted
   always_ff @(posedge clk_i) begin
      if (soft_rst || start_go) begin
         stall_cnt <= '0;
      end else if (run && (|(req & ~tcdm_gnt_i)) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mac_streamer_nch.sv
// Self-checking bench for mac_streamer_nch: a TCDM memory model answers
// source reads, a scoreboard holds expected addresses/data per port.
module tb_mac_streamer_nch;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned LEN_W = 16;
   localparam int unsigned NB_SRC = 3;
   localparam int unsigned NB_SNK = 1;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned NCH = NB_SRC + NB_SNK;

   logic                     clk = 1'b0;
   logic                     rst_i = 1'b1;
   logic                     enable_i = 1'b1;
   logic                     clear_i = 1'b0;
   logic                     start_i = 1'b0;
   logic [NB_SRC*AW-1:0]     src_base_i = '0;
   logic [NB_SRC*AW-1:0]     src_stride_i = '0;
   logic [NB_SRC*LEN_W-1:0]  src_len_i = '0;
   logic [NB_SNK*AW-1:0]     snk_base_i = '0;
   logic [NB_SNK*AW-1:0]     snk_stride_i = '0;
   logic [NB_SNK*LEN_W-1:0]  snk_len_i = '0;
   logic                     busy_o;
   logic                     done_o;
   logic [NB_SRC-1:0]        src_done_o;
   logic [NB_SNK-1:0]        snk_done_o;
   logic [NCH-1:0]           tcdm_req_o;
   logic [NCH-1:0]           tcdm_gnt_i = '0;
   logic [NCH*AW-1:0]        tcdm_add_o;
   logic [NCH-1:0]           tcdm_wen_o;
   logic [NCH*DW/8-1:0]      tcdm_be_o;
   logic [NCH*DW-1:0]        tcdm_data_o;
   logic [NCH*DW-1:0]        tcdm_r_data_i = '0;
   logic [NCH-1:0]           tcdm_r_valid_i = '0;
   logic [NB_SRC-1:0]        src_valid_o;
   logic [NB_SRC-1:0]        src_ready_i = '0;
   logic [NB_SRC*DW-1:0]     src_data_o;
   logic [NB_SNK-1:0]        snk_valid_i = '0;
   logic [NB_SNK-1:0]        snk_ready_o;
   logic [NB_SNK*DW-1:0]     snk_data_i = '0;
   logic [31:0]              stall_cnt_o;

   mac_streamer_nch #(
      .DW(DW), .AW(AW), .LEN_W(LEN_W), .NB_SRC(NB_SRC), .NB_SNK(NB_SNK), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i), .start_i(start_i),
      .src_base_i(src_base_i), .src_stride_i(src_stride_i), .src_len_i(src_len_i),
      .snk_base_i(snk_base_i), .snk_stride_i(snk_stride_i), .snk_len_i(snk_len_i),
      .busy_o(busy_o), .done_o(done_o), .src_done_o(src_done_o), .snk_done_o(snk_done_o),
      .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
      .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
      .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
      .src_valid_o(src_valid_o), .src_ready_i(src_ready_i), .src_data_o(src_data_o),
      .snk_valid_i(snk_valid_i), .snk_ready_o(snk_ready_o), .snk_data_i(snk_data_i),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t0 = 0;

   // stimulus configuration / model state
   logic [31:0] sb [NB_SRC];
   logic [31:0] ss [NB_SRC];
   int          sl [NB_SRC];
   logic [31:0] kb, ks;
   int          kl;
   bit          gnt_rand = 1'b0;
   bit          ready_rand = 1'b0;
   bit          ready_lvl = 1'b1;
   logic [NCH-1:0]    rsp_valid = '0;
   logic [NCH*DW-1:0] rsp_data = '0;

   // scoreboard
   logic [31:0] exp_addr [NB_SRC][$];
   logic [31:0] exp_sdat [NB_SRC][$];
   logic [31:0] exp_wr_addr [$];
   logic [31:0] exp_wr_data [$];
   logic [31:0] offer [$];
   int          snk_acc = 0;

   // per-run observations
   int          first_valid = -1;
   int          done_rel = -1;
   logic        busy_at_done = 1'b1;
   logic [NB_SRC-1:0] done_at1 = '0;
   int          fire_cnt [NCH];
   int          req_seen [NCH];
   int          late_ready = 0;
   int          stall_ref = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model, grant/ready generation and scoreboard comparisons
   initial forever begin
      @(negedge clk);
      tcdm_r_valid_i = rsp_valid;
      tcdm_r_data_i  = rsp_data;
      rsp_valid      = '0;
      for (int p = 0; p < NCH; p++)
         tcdm_gnt_i[p] = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < NB_SRC; i++)
         src_ready_i[i] = ready_rand ? 1'($urandom_range(0, 1)) : ready_lvl;
      snk_valid_i[0] = (offer.size() != 0);
      snk_data_i     = (offer.size() != 0) ? offer[0] : '0;
      #1;
      if (busy_o && (|(tcdm_req_o & ~tcdm_gnt_i))) stall_ref++;
      if (cyc - t0 == 1) done_at1 = src_done_o;
      for (int p = 0; p < NCH; p++)
         if (tcdm_req_o[p]) req_seen[p]++;
      for (int p = 0; p < NB_SRC; p++) begin
         if (tcdm_req_o[p] && tcdm_gnt_i[p]) begin
            logic [31:0] a;
            a = tcdm_add_o[p*AW +: AW];
            fire_cnt[p]++;
            rsp_valid[p] = 1'b1;
            rsp_data[p*DW +: DW] = memf(a);
            if (exp_addr[p].size() == 0) check("rd_unexpected", 64'(exp_addr[p].size()), 64'd1);
            else check($sformatf("rd_addr%0d", p), 64'(a), 64'(exp_addr[p].pop_front()));
         end
      end
      if (tcdm_req_o[NB_SRC] && tcdm_gnt_i[NB_SRC]) begin
         fire_cnt[NB_SRC]++;
         if (exp_wr_addr.size() == 0) check("wr_unexpected", 64'(exp_wr_addr.size()), 64'd1);
         else begin
            check("wr_addr", 64'(tcdm_add_o[NB_SRC*AW +: AW]), 64'(exp_wr_addr.pop_front()));
            check("wr_data", 64'(tcdm_data_o[NB_SRC*DW +: DW]), 64'(exp_wr_data.pop_front()));
         end
      end
      for (int i = 0; i < NB_SRC; i++) begin
         if (src_valid_o[i] && src_ready_i[i]) begin
            if (i == 0 && first_valid < 0) first_valid = cyc - t0;
            if (exp_sdat[i].size() == 0) check("stream_unexpected", 64'(exp_sdat[i].size()), 64'd1);
            else check($sformatf("stream_data%0d", i), 64'(src_data_o[i*DW +: DW]), 64'(exp_sdat[i].pop_front()));
         end
      end
      if (busy_o && snk_acc >= kl && snk_ready_o[0]) late_ready++;
      if (snk_valid_i[0] && snk_ready_o[0]) begin
         exp_wr_addr.push_back(kb + 32'(snk_acc) * ks);
         exp_wr_data.push_back(offer[0]);
         void'(offer.pop_front());
         snk_acc++;
      end
      if (done_o && done_rel < 0) begin
         done_rel = cyc - t0;
         busy_at_done = busy_o;
      end
   end

   task automatic set_cfg(input logic [31:0] b0, input logic [31:0] s0, input int l0,
                          input int l1, input int l2, input logic [31:0] b, input logic [31:0] s, input int l);
      sb[0] = b0; ss[0] = s0; sl[0] = l0;
      sb[1] = 32'h0000_1800; ss[1] = 32'd12; sl[1] = l1;
      sb[2] = 32'h0000_3000; ss[2] = 32'hFFFF_FFFC; sl[2] = l2;
      kb = b; ks = s; kl = l;
   endtask

   task automatic launch();
      for (int i = 0; i < NB_SRC; i++) begin
         src_base_i[i*AW +: AW]      = sb[i];
         src_stride_i[i*AW +: AW]    = ss[i];
         src_len_i[i*LEN_W +: LEN_W] = LEN_W'(sl[i]);
         for (int k = 0; k < sl[i]; k++) begin
            exp_addr[i].push_back(sb[i] + 32'(k) * ss[i]);
            exp_sdat[i].push_back(memf(sb[i] + 32'(k) * ss[i]));
         end
      end
      snk_base_i = kb; snk_stride_i = ks; snk_len_i = LEN_W'(kl);
      snk_acc = 0; late_ready = 0; stall_ref = 0;
      first_valid = -1; done_rel = -1; busy_at_done = 1'b1;
      for (int p = 0; p < NCH; p++) begin
         fire_cnt[p] = 0;
         req_seen[p] = 0;
      end
      start_i = 1'b1;
      t0 = cyc;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_rel < 0 && n < budget) begin
         step();
         n++;
      end
      check("done_seen", 64'(done_rel >= 0), 64'd1);
      step();
   endtask

   task automatic drained(input string tag);
      int left = 0;
      for (int i = 0; i < NB_SRC; i++) left += exp_addr[i].size() + exp_sdat[i].size();
      left += exp_wr_addr.size();
      check({tag, "_drained"}, 64'(left), 64'd0);
   endtask

   task automatic flush();
      for (int i = 0; i < NB_SRC; i++) begin
         exp_addr[i].delete();
         exp_sdat[i].delete();
      end
      exp_wr_addr.delete();
      exp_wr_data.delete();
   endtask

   initial begin
      for (int p = 0; p < NCH; p++) begin
         fire_cnt[p] = 0;
         req_seen[p] = 0;
      end
      set_cfg(32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0);
      repeat (3) step();
      rst_i = 1'b0;
      step();

      // reset state
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_req", 64'(tcdm_req_o), 64'd0);
      check("rst_wen", 64'(tcdm_wen_o), 64'hF);
      check("rst_valid_ready", 64'({src_valid_o, snk_ready_o}), 64'd0);
      check("rst_chan_done", 64'({src_done_o, snk_done_o}), 64'd0);
      check("rst_stall", 64'(stall_cnt_o), 64'd0);

      // single source, full throughput
      set_cfg(32'h100, 32'd4, 8, 0, 0, 32'h0, 32'h0, 0);
      launch();
      wait_done(60);
      check("t1_first_valid", 64'(first_valid), 64'd3);
      check("t1_done_cycle", 64'(done_rel), 64'd11);
      check("t1_busy_at_done", 64'(busy_at_done), 64'd0);
      check("t1_src_done", 64'(src_done_o), 64'h7);
      drained("t1");

      // back-pressured source: credit limits reads to the FIFO depth
      set_cfg(32'h400, 32'd4, 8, 0, 0, 32'h0, 32'h0, 0);
      ready_lvl = 1'b0;
      launch();
      repeat (19) step();
      check("t2_reads_stalled", 64'(fire_cnt[0]), 64'(FIFO_DEPTH));
      check("t2_valid_stalled", 64'(src_valid_o[0]), 64'd1);
      ready_lvl = 1'b1;
      wait_done(60);
      drained("t2");

      // sink with extra words offered
      set_cfg(32'h0, 32'h0, 0, 0, 0, 32'h200, 32'd8, 3);
      for (int k = 0; k < 5; k++) offer.push_back(32'hC0DE_0000 + 32'(k));
      launch();
      wait_done(60);
      check("t3_offer_left", 64'(offer.size()), 64'd2);
      check("t3_late_ready", 64'(late_ready), 64'd0);
      check("t3_snk_done", 64'(snk_done_o), 64'd1);
      check("t3_writes", 64'(fire_cnt[NB_SRC]), 64'd3);
      offer.delete();
      drained("t3");

      // all channels, random grant and ready, brief freeze
      set_cfg(32'h1000, 32'd4, 5, 6, 7, 32'h4000, 32'd4, 6);
      for (int k = 0; k < 6; k++) offer.push_back(32'h00AB_0000 ^ (32'(k) * 32'h1111));
      gnt_rand = 1'b1;
      ready_rand = 1'b1;
      launch();
      repeat (8) step();
      enable_i = 1'b0;
      repeat (5) step();
      enable_i = 1'b1;
      wait_done(600);
`ifdef MAC_STREAMER_STALL_CNT_EN
      check("t4_stall_cnt", 64'(stall_cnt_o), 64'(stall_ref));
`else
      check("t4_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
      check("t4_all_done", 64'({src_done_o, snk_done_o}), 64'hF);
      gnt_rand = 1'b0;
      ready_rand = 1'b0;
      ready_lvl = 1'b1;
      drained("t4");

      // zero-length channels beside a len=2 channel
      set_cfg(32'h500, 32'd4, 2, 0, 0, 32'h0, 32'h0, 0);
      launch();
      wait_done(60);
      check("t5_done_at1", 64'(done_at1), 64'h6);
      check("t5_no_req_len0", 64'(req_seen[1] + req_seen[2] + req_seen[3]), 64'd0);
      check("t5_done_cycle", 64'(done_rel), 64'd5);
      drained("t5");

      // soft clear with a read response in flight, then a fresh run
      set_cfg(32'h600, 32'd4, 8, 0, 0, 32'h0, 32'h0, 0);
      launch();
      step();
      step();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check("t6_busy_after_clr", 64'(busy_o), 64'd0);
      check("t6_req_after_clr", 64'(tcdm_req_o), 64'd0);
      check("t6_valid_after_clr", 64'(src_valid_o), 64'd0);
      check("t6_done_after_clr", 64'(src_done_o), 64'd0);
      flush();
      repeat (3) step();
      set_cfg(32'h700, 32'd4, 4, 0, 0, 32'h0, 32'h0, 0);
      launch();
      wait_done(60);
      check("t6_src_done", 64'(src_done_o), 64'h7);
      drained("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
